// File: rtl/axi_id_remap_alloc.sv
// AXI ID remap allocator: maps wide input IDs onto a small pool of output IDs with per-entry outstanding counts.
// Optional occupancy/high-water statistics ports are enabled by defining AXI_ID_REMAP_ALLOC_STATS_EN.
module axi_id_remap_alloc #(
  parameter int InIdWidth = 8,
  parameter int TableSize = 4,
  parameter int MaxTxns = 4,
  localparam int OutIdWidth = $clog2(TableSize),
  localparam int CntW = $clog2(MaxTxns + 1)
`ifdef AXI_ID_REMAP_ALLOC_STATS_EN
  , localparam int OccW = $clog2(TableSize + 1)
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  input  logic [InIdWidth-1:0]  push_in_id_i,
  output logic                  push_ready_o,
  output logic [OutIdWidth-1:0] push_out_id_o,
  input  logic                  pop_valid_i,
  input  logic [OutIdWidth-1:0] pop_out_id_i,
  output logic [InIdWidth-1:0]  pop_in_id_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
`ifdef AXI_ID_REMAP_ALLOC_STATS_EN
  , output logic [OccW-1:0]     occupancy_o,
  output logic [OccW-1:0]       high_water_o
`endif
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  logic [TableSize-1:0] valid_r;
  logic [InIdWidth-1:0] in_id_r [TableSize];
  logic [CntW-1:0]      cnt_r   [TableSize];
  logic                 full_r;
  logic                 empty_r;
  logic                 err_r;

  logic [TableSize-1:0]  valid_nxt_s;
  logic [InIdWidth-1:0]  in_id_nxt_s [TableSize];
  logic [CntW-1:0]       cnt_nxt_s   [TableSize];
  logic                  match_s;
  logic [OutIdWidth-1:0] match_idx_s;
  logic                  free_s;
  logic [OutIdWidth-1:0] free_idx_s;
  logic                  push_ready_s;
  logic [OutIdWidth-1:0] push_out_id_s;
  logic                  push_fire_s;
  logic                  pop_hit_s;

  // Look up a live entry holding the incoming ID, and the lowest free entry.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = '0;
    free_s      = 1'b0;
    free_idx_s  = '0;
    for (int i = 0; i < TableSize; i++) begin
      if (valid_r[i] && (in_id_r[i] == push_in_id_i)) begin
        match_s     = 1'b1;
        match_idx_s = OutIdWidth'(i);
      end else begin
        match_s     = match_s;
      end
    end
    // Descending scan so the lowest free index wins.
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_s     = 1'b1;
        free_idx_s = OutIdWidth'(i);
      end else begin
        free_s     = free_s;
      end
    end
  end

  // Push decision: a matching entry is reused (or stalls when saturated), never duplicated.
  always_comb begin
    push_ready_s  = 1'b0;
    push_out_id_s = '0;
    if (match_s) begin
      push_ready_s  = (cnt_r[match_idx_s] < MaxCnt);
      push_out_id_s = match_idx_s;
    end else begin
      push_ready_s  = free_s;
      push_out_id_s = free_idx_s;
    end
  end

  assign push_fire_s = push_valid_i && push_ready_s;
  assign pop_hit_s   = pop_valid_i && valid_r[pop_out_id_i];

  // Per-entry next state; a push and a pop to the same entry cancel out.
  always_comb begin
    valid_nxt_s = valid_r;
    in_id_nxt_s = in_id_r;
    cnt_nxt_s   = cnt_r;
    for (int i = 0; i < TableSize; i++) begin
      if (push_fire_s && (push_out_id_s == OutIdWidth'(i)) &&
          !(pop_hit_s && (pop_out_id_i == OutIdWidth'(i)))) begin
        valid_nxt_s[i] = 1'b1;
        in_id_nxt_s[i] = push_in_id_i;
        cnt_nxt_s[i]   = cnt_r[i] + CntW'(1);
      end else if (pop_hit_s && (pop_out_id_i == OutIdWidth'(i)) &&
                   !(push_fire_s && (push_out_id_s == OutIdWidth'(i)))) begin
        valid_nxt_s[i] = (cnt_r[i] != CntW'(1));
        cnt_nxt_s[i]   = cnt_r[i] - CntW'(1);
      end else begin
        cnt_nxt_s[i]   = cnt_r[i];
      end
    end
  end

  // Table state and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= '0;
      for (int i = 0; i < TableSize; i++) begin
        in_id_r[i] <= '0;
        cnt_r[i]   <= '0;
      end
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      in_id_r <= in_id_nxt_s;
      cnt_r   <= cnt_nxt_s;
      full_r  <= &valid_nxt_s;
      empty_r <= ~|valid_nxt_s;
      err_r   <= pop_valid_i && !valid_r[pop_out_id_i];
    end
  end

  assign push_ready_o  = push_ready_s;
  assign push_out_id_o = push_out_id_s;
  assign pop_in_id_o   = in_id_r[pop_out_id_i];
  assign full_o        = full_r;
  assign empty_o       = empty_r;
  assign err_o         = err_r;

`ifdef AXI_ID_REMAP_ALLOC_STATS_EN
  logic [OccW-1:0] occupancy_r;
  logic [OccW-1:0] high_water_r;
  logic [OccW-1:0] occ_nxt_s;

  function automatic logic [OccW-1:0] popcount(input logic [TableSize-1:0] v);
    logic [OccW-1:0] n;
    n = '0;
    for (int i = 0; i < TableSize; i++) begin
      if (v[i]) begin
        n = n + OccW'(1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  assign occ_nxt_s = popcount(valid_nxt_s);

  // Live-entry count and its running maximum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_r  <= '0;
      high_water_r <= '0;
    end else begin
      occupancy_r <= occ_nxt_s;
      if (occ_nxt_s > high_water_r) begin
        high_water_r <= occ_nxt_s;
      end else begin
        high_water_r <= high_water_r;
      end
    end
  end

  assign occupancy_o  = occupancy_r;
  assign high_water_o = high_water_r;
`endif

endmodule
